bus_wait_gen: RTL
=================

Name: bus_wait_gen

Overview:
- Bus cycle wait-state generator between cpu_top bus outputs (addr, rd, wr, mem_io) and its WAIT input.
- Classifies each bus cycle as fast memory, slow memory or IO. Stretches the cycle by a per-class number of wait cycles; IO cycles are further extended by a peripheral ready line.
- Drives WAIT back to cpu_top and reports cycle completion for bus monitors and peripherals.

Parameters:
- ADDR_W, 22, bus address width.
- SLOW_BASE, 22'h200000, memory addresses >= this value are slow memory.
- MEM_WAIT, 0, wait cycles for fast memory (0..15).
- SLOW_WAIT, 3, wait cycles for slow memory (0..15).
- IO_WAIT, 2, minimum wait cycles for IO (0..15).
- TIMEOUT, 255, max ext_rdy-extension cycles; used only with BUS_TIMEOUT_EN (1..255).

Ports:
- clk  in  1  system clock (output of clock block).
- arst  in  1  reset; one clock, reset is synchronous and active-high.
- addr  in  ADDR_W  CPU bus address.
- rd  in  1  CPU read strobe, active-high.
- wr  in  1  CPU write strobe, active-high.
- mem_io  in  1  1 = memory cycle, 0 = IO cycle.
- ext_rdy  in  1  IO peripheral ready, active-high; ignored for memory cycles.
- err_clr  in  1  clears bus_err (optional feature).
- WAIT  out  1  stall request to cpu_top, active-high.
- cyc_done  out  1  one-clock pulse on the cycle a bus access completes.
- cyc_class  out  2  latched class: 00 fast, 01 slow, 10 IO, 11 unused.
- bus_err  out  1  sticky timeout flag (optional feature).

Behaviour:
- Strobe: stb = rd | wr. Start = stb high while state is IDLE.
- On start, class is latched from mem_io/addr. addr/mem_io changes later in the cycle are ignored.
- N = wait count of the latched class.
- States: IDLE, COUNT, HOLD. cnt is a 4-bit down-counter.
- IDLE:
  - WAIT = (N != 0) combinationally in the start cycle.
  - If start and N != 0: go to COUNT, cnt <= N-1.
  - If start and N == 0 and (memory or ext_rdy): cyc_done = 1 in the start cycle; go to HOLD.
  - If start, N == 0, IO and !ext_rdy: WAIT = 1; go to COUNT with cnt = 0.
- COUNT:
  - WAIT = (cnt != 0) | (class == IO & !ext_rdy).
  - cnt decrements while nonzero.
  - When WAIT evaluates 0: cyc_done = 1 that cycle; go to HOLD.
  - Result: total WAIT cycles = N for memory; max(N, cycles until ext_rdy) for IO.
- HOLD: WAIT = 0. Go to IDLE when stb = 0. A strobe held across cycles never starts a second access.
- Abort: stb drops in COUNT → go to IDLE next clock, WAIT = 0 combinationally, no cyc_done.
- rd and wr both high: treated as one access (wr precedence is irrelevant here).
- Reset (any state, including mid-cycle):
  - state = IDLE, cnt = 0, cyc_class = 00, bus_err = 0.
  - Combinational outputs WAIT = 0 and cyc_done = 0 while arst is high.
- Combinational path from rd/wr/addr/mem_io/ext_rdy to WAIT is required so cpu_top stalls in the first cycle.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter runs in COUNT once cnt == 0 and class == IO and !ext_rdy.
  - When it reaches TIMEOUT, the cycle is force-completed: WAIT = 0, cyc_done = 1, bus_err <= 1, go to HOLD.
  - The counter clears on entering COUNT.
  - bus_err clears on err_clr; a simultaneous set wins over clear.
- Without the macro:
  - No counter; IO waits for ext_rdy indefinitely.
  - bus_err is tied 0 and err_clr is ignored. Ports remain present.

Test Plan:
- Reset: arst high 2 clocks with rd = 1 → WAIT = 0, cyc_done = 0, cyc_class = 00; after release, rd already high starts an access on the first clock.
- Fast read, MEM_WAIT = 0, mem_io = 1, addr = 22'h000100, rd 1 clock → WAIT never high, cyc_done in the same cycle, class 00.
- Slow write, SLOW_WAIT = 3, addr = 22'h200010, wr held → WAIT high exactly 3 clocks, cyc_done on the 4th clock, class 01; wr held 3 more clocks → no second cyc_done.
- IO read, IO_WAIT = 2, ext_rdy low 6 clocks then high → WAIT high 6 clocks, cyc_done on the clock ext_rdy rises, class 10.
- Abort: slow read with rd dropped after 1 WAIT clock → WAIT low that cycle, no cyc_done, next rd starts a fresh 3-cycle count.
- BUS_TIMEOUT_EN, TIMEOUT = 10, IO read, ext_rdy stuck low → cyc_done after 10 extension clocks, bus_err = 1 stays set until err_clr pulse, then 0.

Source files
------------

// File: rtl/bus_wait_gen.sv
// Bus cycle wait-state generator: classifies CPU bus cycles and stretches them.
// Optional bus timeout and sticky bus_err enabled with `define BUS_TIMEOUT_EN.
module bus_wait_gen #(
    parameter int ADDR_W    = 22,
    parameter logic [ADDR_W-1:0] SLOW_BASE = 22'h200000,
    parameter int MEM_WAIT  = 0,
    parameter int SLOW_WAIT = 3,
    parameter int IO_WAIT   = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic              mem_io,
    input  logic              ext_rdy,
    input  logic              err_clr,
    output logic              WAIT,
    output logic              cyc_done,
    output logic [1:0]        cyc_class,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] CLS_FAST = 2'b00;
    localparam logic [1:0] CLS_SLOW = 2'b01;
    localparam logic [1:0] CLS_IO   = 2'b10;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cls_q, cls_d;
    logic       stb;
    logic [1:0] cls_now;
    logic [3:0] n_now;
    logic       wait_c;
    logic       done_c;

    function automatic logic [3:0] n_of(input logic [1:0] c);
        unique case (c)
            CLS_FAST: n_of = 4'(MEM_WAIT);
            CLS_SLOW: n_of = 4'(SLOW_WAIT);
            default:  n_of = 4'(IO_WAIT);
        endcase
    endfunction

    assign stb = rd | wr;

    // Classify the cycle from the live bus; only used in the start cycle
    always_comb begin
        if (!mem_io) begin
            cls_now = CLS_IO;
        end else if (addr >= SLOW_BASE) begin
            cls_now = CLS_SLOW;
        end else begin
            cls_now = CLS_FAST;
        end
        n_now = n_of(cls_now);
    end

`ifdef BUS_TIMEOUT_EN
    logic [7:0] to_q, to_d;
    logic       err_q, err_d;
`endif

    // Next-state, wait and completion logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cls_d   = cls_q;
        wait_c  = 1'b0;
        done_c  = 1'b0;
`ifdef BUS_TIMEOUT_EN
        to_d    = to_q;
        err_d   = err_q & ~err_clr;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (stb) begin
                    cls_d = cls_now;
`ifdef BUS_TIMEOUT_EN
                    to_d  = 8'd0;
`endif
                    if (n_now != 4'd0) begin
                        wait_c  = 1'b1;
                        cnt_d   = n_now - 4'd1;
                        state_d = ST_COUNT;
                    end else if (mem_io || ext_rdy) begin
                        done_c  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        wait_c  = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (!stb) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_c = (cnt_q != 4'd0) |
                             ((cls_q == CLS_IO) & ~ext_rdy);
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
`ifdef BUS_TIMEOUT_EN
                    if ((cnt_q == 4'd0) && (cls_q == CLS_IO) && !ext_rdy) begin
                        if (to_q == 8'(TIMEOUT)) begin
                            wait_c = 1'b0;
                            err_d  = 1'b1;
                        end else begin
                            to_d = to_q + 8'd1;
                        end
                    end
`endif
                    if (!wait_c) begin
                        done_c  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stb) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cls_q   <= CLS_FAST;
`ifdef BUS_TIMEOUT_EN
            to_q    <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
`ifdef BUS_TIMEOUT_EN
            to_q    <= to_d;
            err_q   <= err_d;
`endif
        end
    end

    assign WAIT      = wait_c & ~arst;
    assign cyc_done  = done_c & ~arst;
    assign cyc_class = cls_q;

`ifdef BUS_TIMEOUT_EN
    assign bus_err = err_q;
`else
    logic unused_sig;
    assign unused_sig = err_clr & (TIMEOUT != 0);
    assign bus_err    = 1'b0;
`endif

endmodule
